test_result_monitor: RTL and testbench
======================================

// Module: test_result_monitor
// PURPOSE
//  Synthesisable pass/fail checker for CPU regression ROMs; successor of the fixed-time,
//  single-byte bench check. Snoops the data-memory write port of top, records the last byte
//  written to NCHAN configurable addresses, then compares each against an expected value.
//  Test ends on a halt strobe or a cycle timeout. Reports pass/fail/timeout plus the first
//  failing channel.
// PARAMETERS
//  NCHAN           4    number of checked address/expected-value channels (1..16)
//  ADDR_W          16   memory address width
//  TIMEOUT_CYCLES  200  RUN cycles before forced TIMEOUT (200 = 4000 ns at a 20 ns period)
//  CNT_W           16   cycle counter width; must hold TIMEOUT_CYCLES
//  IDX_W           $clog2(NCHAN) (min 1), derived; not overridden
// PORTS
//  ph1        in   1       clock; all state updates on rising edge
//  resetb     in   1       asynchronous, active-low reset
//  cfg_wr     in   1       write expected entry; honoured only in IDLE/PASS/FAIL/TIMEOUT
//  cfg_idx    in   IDX_W   channel to configure
//  cfg_addr   in   ADDR_W  address watched by channel
//  cfg_data   in   8       expected final byte for channel
//  cfg_en     in   1       channel enable written with entry; disabled channels always pass
//  start      in   1       begin a run
//  halt       in   1       CPU reached end-of-test loop; ends RUN
//  mem_we     in   1       memory write strobe
//  mem_addr   in   ADDR_W  memory write address
//  mem_wdata  in   8       memory write data
//  busy       out  1       RUN or CHECK
//  done       out  1       in PASS, FAIL or TIMEOUT
//  pass       out  1       in PASS
//  fail       out  1       in FAIL or TIMEOUT
//  timeout    out  1       in TIMEOUT
//  fail_idx   out  IDX_W   first failing channel (valid when state is FAIL)
//  fail_data  out  8       byte captured on fail_idx; 0 if never written
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; cfg table (addr, data, en) cleared; seen/captured cleared.
//  - States: IDLE, RUN, CHECK, PASS, FAIL, TIMEOUT.
//  - IDLE/PASS/FAIL/TIMEOUT + start: go to RUN next edge; counter=0; all seen bits and
//    captured bytes cleared. A start is ignored in RUN/CHECK. A cfg_wr in the same cycle as
//    start still lands, and the new entry is used for that run.
//  - RUN: counter increments every cycle. A mem_we whose mem_addr equals cfg_addr of an enabled
//    channel updates that channel's captured byte and sets its seen bit. The last write wins.
//    Several channels with the same address all capture.
//  - RUN exit: halt=1 -> CHECK. Else counter==TIMEOUT_CYCLES-1 -> TIMEOUT. If halt and
//    timeout coincide, halt wins. A write in the exit cycle is still captured.
//  - CHECK: scans one channel per cycle, idx 0..NCHAN-1. Channel fails if enabled and
//    (!seen || captured!=expected). The first failure goes to FAIL, latching fail_idx/fail_data.
//    All channels clean -> PASS. Latency from halt to done = NCHAN+1 cycles worst case.
//  - PASS/FAIL/TIMEOUT are sticky until start or reset. mem writes there are ignored.
//  - Counter saturates; never wraps. Async reset at any time returns to IDLE the same instant.
//  - All outputs are registered or decoded from the registered state only.
//  - No combinational path from inputs to outputs.
// CONFIGURATION
//  TRM_CYCLE_REPORT_EN defined: adds output run_cycles [CNT_W-1:0]. It holds the counter value
//    at RUN exit (cycles from start to halt/timeout). It is reset to 0 and cleared on start.
//  TRM_CYCLE_REPORT_EN undefined: port and holding register absent; behaviour otherwise identical.
// TESTING
//  1 cfg ch0 addr 0x0015 exp 0x7F; start; write 0x7F@0x0015; halt -> pass=1, done=1 by NCHAN+1 cycles
//  2 same cfg; write 0x7F then 0x80 @0x0015; halt -> fail=1, fail_idx=0, fail_data=0x80
//  3 cfg ch1 addr 0x0020 exp 0x01, no write to it; halt -> fail=1, fail_idx=1, fail_data=0x00
//  4 start, never halt -> timeout=1, fail=1 after exactly 200 RUN cycles; halt in that cycle -> CHECK
//  5 resetb low mid-RUN -> all outputs 0 immediately; start again with cfg reloaded -> normal pass
//  6 TRM_CYCLE_REPORT_EN: halt 37 cycles after start -> run_cycles=36; start clears to 0

Source files
------------

// File: rtl/test_result_monitor_if.sv
// test_result_monitor_if
//   Bus bundle for test_result_monitor: the expected-value configuration port
//   and the snooped data-memory write port of the CPU under test.
//   Parameters:
//     ADDR_W  memory address width
//     NCHAN   number of checked channels (sets cfg_idx width)
//   Signals:
//     cfg_wr / cfg_idx / cfg_addr / cfg_data / cfg_en   configuration write
//     mem_we / mem_addr / mem_wdata                     memory write snoop
//   Modports:
//     master  drives every signal (CPU top / bench side)
//     slave   receives every signal (monitor side)
interface test_result_monitor_if #(
  parameter int ADDR_W = 16,
  parameter int NCHAN  = 4
);
  localparam int IDX_W = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  logic              cfg_wr;
  logic [IDX_W-1:0]  cfg_idx;
  logic [ADDR_W-1:0] cfg_addr;
  logic [7:0]        cfg_data;
  logic              cfg_en;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport master (
    output cfg_wr, cfg_idx, cfg_addr, cfg_data, cfg_en,
    output mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input cfg_wr, cfg_idx, cfg_addr, cfg_data, cfg_en,
    input mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/test_result_monitor.sv
// test_result_monitor
//   Pass/fail checker for CPU regression ROMs. Snoops data-memory writes,
//   keeps the last byte written to each of NCHAN configured addresses, and on
//   halt scans the channels one per cycle against their expected bytes. A run
//   that never halts ends in TIMEOUT after TIMEOUT_CYCLES RUN cycles.
//   Ports:
//     ph1, resetb        clock (rising edge), async active-low reset
//     bus (slave)        cfg_* configuration write, mem_* write snoop
//     start, halt        begin a run / CPU reached end-of-test loop
//     busy               RUN or CHECK
//     done, pass, fail   result flags (fail also set on timeout)
//     timeout            run ended by the cycle limit
//     fail_idx/fail_data first failing channel and the byte it captured
//   Optional build macro TRM_CYCLE_REPORT_EN adds run_cycles: the cycle
//   counter value at RUN exit, cleared by reset and by start.
module test_result_monitor #(
  parameter  int NCHAN          = 4,
  parameter  int ADDR_W         = 16,
  parameter  int TIMEOUT_CYCLES = 200,
  parameter  int CNT_W          = 16,
  localparam int IDX_W          = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic                 ph1,
  input  logic                 resetb,
  test_result_monitor_if.slave bus,
  input  logic                 start,
  input  logic                 halt,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic                 timeout,
  output logic [IDX_W-1:0]     fail_idx,
  output logic [7:0]           fail_data
`ifdef TRM_CYCLE_REPORT_EN
  ,
  output logic [CNT_W-1:0]     run_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_CHECK,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  scan_idx;

  logic [ADDR_W-1:0] addr_q [NCHAN];
  logic [7:0]        exp_q  [NCHAN];
  logic [NCHAN-1:0]  en_q;
  logic [7:0]        cap_q  [NCHAN];
  logic [NCHAN-1:0]  seen_q;

  logic              cfg_open;
  logic              ch_bad;

  // Output flags are registered alongside the state: each transition loads
  // the flag set belonging to the state being entered.
  // Bit order: {busy, done, pass, fail, timeout}.
  function automatic logic [4:0] flags_of(input state_t s);
    case (s)
      S_RUN, S_CHECK: return 5'b10000;
      S_PASS:         return 5'b01100;
      S_FAIL:         return 5'b01010;
      S_TIMEOUT:      return 5'b01011;
      default:        return 5'b00000;
    endcase
  endfunction

  always_comb begin
    cfg_open = (state == S_IDLE) || (state == S_PASS) ||
               (state == S_FAIL) || (state == S_TIMEOUT);
  end

  // Channel under scan fails if enabled and either never written or holding
  // a byte other than the expected one.
  always_comb begin
    ch_bad = en_q[scan_idx] &&
             (!seen_q[scan_idx] || (cap_q[scan_idx] != exp_q[scan_idx]));
  end

  always_ff @(posedge ph1 or negedge resetb) begin
    if (!resetb) begin
      state    <= S_IDLE;
      {busy, done, pass, fail, timeout} <= '0;
      cnt      <= '0;
      scan_idx <= '0;
      fail_idx <= '0;
      fail_data <= '0;
      en_q     <= '0;
      seen_q   <= '0;
      for (int unsigned i = 0; i < NCHAN; i++) begin
        addr_q[i] <= '0;
        exp_q[i]  <= '0;
        cap_q[i]  <= '0;
      end
`ifdef TRM_CYCLE_REPORT_EN
      run_cycles <= '0;
`endif
    end else begin
      // Configuration lands whenever no run is in progress, including the
      // cycle that carries start, so that entry is used by the new run.
      if (cfg_open && bus.cfg_wr) begin
        for (int unsigned i = 0; i < NCHAN; i++) begin
          if (bus.cfg_idx == IDX_W'(i)) begin
            addr_q[i] <= bus.cfg_addr;
            exp_q[i]  <= bus.cfg_data;
            en_q[i]   <= bus.cfg_en;
          end
        end
      end

      case (state)
        S_RUN: begin
          if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
          // Every matching enabled channel captures, including in the exit cycle.
          for (int unsigned i = 0; i < NCHAN; i++) begin
            if (bus.mem_we && en_q[i] && (bus.mem_addr == addr_q[i])) begin
              cap_q[i]  <= bus.mem_wdata;
              seen_q[i] <= 1'b1;
            end
          end
          if (halt) begin
            state    <= S_CHECK;
            {busy, done, pass, fail, timeout} <= flags_of(S_CHECK);
            scan_idx <= '0;
`ifdef TRM_CYCLE_REPORT_EN
            run_cycles <= cnt;
`endif
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state <= S_TIMEOUT;
            {busy, done, pass, fail, timeout} <= flags_of(S_TIMEOUT);
`ifdef TRM_CYCLE_REPORT_EN
            run_cycles <= cnt;
`endif
          end
        end

        S_CHECK: begin
          if (ch_bad) begin
            state     <= S_FAIL;
            {busy, done, pass, fail, timeout} <= flags_of(S_FAIL);
            fail_idx  <= scan_idx;
            fail_data <= cap_q[scan_idx];
          end else if (scan_idx == IDX_W'(NCHAN - 1)) begin
            state <= S_PASS;
            {busy, done, pass, fail, timeout} <= flags_of(S_PASS);
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end

        default: begin
          // IDLE / PASS / FAIL / TIMEOUT: sticky until start.
          if (start) begin
            state     <= S_RUN;
            {busy, done, pass, fail, timeout} <= flags_of(S_RUN);
            cnt       <= '0;
            scan_idx  <= '0;
            fail_idx  <= '0;
            fail_data <= '0;
            seen_q    <= '0;
            for (int unsigned i = 0; i < NCHAN; i++) begin
              cap_q[i] <= '0;
            end
`ifdef TRM_CYCLE_REPORT_EN
            run_cycles <= '0;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_test_result_monitor.sv
// tb_test_result_monitor
//   Directed stimulus against test_result_monitor with a cycle-level
//   behavioural model of run/verdict timing and a per-cycle compare process,
//   plus literal expectations on the headline scenarios.
module tb_test_result_monitor;
  localparam int NCHAN          = 4;
  localparam int ADDR_W         = 16;
  localparam int TIMEOUT_CYCLES = 200;
  localparam int CNT_W          = 16;
  localparam int IDX_W          = 2;

  logic ph1 = 1'b0;
  logic resetb = 1'b0;
  logic start = 1'b0;
  logic halt = 1'b0;
  logic busy, done, pass, fail, timeout;
  logic [IDX_W-1:0] fail_idx;
  logic [7:0]       fail_data;
`ifdef TRM_CYCLE_REPORT_EN
  logic [CNT_W-1:0] run_cycles;
`endif

  int n_checks = 0;
  int n_errors = 0;

  test_result_monitor_if #(.ADDR_W(ADDR_W), .NCHAN(NCHAN)) bus ();

  test_result_monitor #(
    .NCHAN(NCHAN),
    .ADDR_W(ADDR_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W(CNT_W)
  ) dut (
    .ph1(ph1),
    .resetb(resetb),
    .bus(bus),
    .start(start),
    .halt(halt),
    .busy(busy),
    .done(done),
    .pass(pass),
    .fail(fail),
    .timeout(timeout),
    .fail_idx(fail_idx),
    .fail_data(fail_data)
`ifdef TRM_CYCLE_REPORT_EN
    ,
    .run_cycles(run_cycles)
`endif
  );

  always #10 ph1 = ~ph1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_mode: 0 idle, 1 run, 2 verdict pending, 3 pass, 4 fail, 5 timeout
  int m_mode, m_cnt, m_wait, m_res, m_res_data, m_run;
  bit m_fresh;
  int m_addr [NCHAN];
  int m_exp  [NCHAN];
  bit m_en   [NCHAN];
  int m_cap  [NCHAN];   // -1: never written this run

  // Captured byte of channel i including a write happening this cycle.
  function automatic int eff_cap(input int i);
    if (bus.mem_we && m_en[i] && (int'(bus.mem_addr) == m_addr[i]))
      return int'(bus.mem_wdata);
    return m_cap[i];
  endfunction

  function automatic int first_bad();
    for (int i = 0; i < NCHAN; i++)
      if (m_en[i] && (eff_cap(i) != m_exp[i])) return i;
    return -1;
  endfunction

  function automatic int bad_data(input int k);
    if (k < 0) return 0;
    if (eff_cap(k) < 0) return 0;
    return eff_cap(k);
  endfunction

  always @(posedge ph1 or negedge resetb) begin
    if (!resetb) begin
      m_mode <= 0; m_cnt <= 0; m_wait <= 0; m_res <= -1;
      m_res_data <= 0; m_run <= 0; m_fresh <= 1'b1;
      for (int i = 0; i < NCHAN; i++) begin
        m_addr[i] <= 0; m_exp[i] <= 0; m_en[i] <= 1'b0; m_cap[i] <= -1;
      end
    end else begin
      case (m_mode)
        1: begin
          m_cnt <= m_cnt + 1;
          for (int i = 0; i < NCHAN; i++) m_cap[i] <= eff_cap(i);
          if (halt) begin
            m_mode     <= 2;
            m_res      <= first_bad();
            m_res_data <= bad_data(first_bad());
            // Verdict after one scan cycle per channel up to the failing one.
            m_wait     <= (first_bad() < 0) ? NCHAN : first_bad() + 1;
            m_run      <= m_cnt;
          end else if (m_cnt == TIMEOUT_CYCLES - 1) begin
            m_mode <= 5;
            m_run  <= m_cnt;
          end
        end
        2: begin
          if (m_wait == 1) m_mode <= (m_res < 0) ? 3 : 4;
          else m_wait <= m_wait - 1;
        end
        default: begin
          if (bus.cfg_wr) begin
            m_addr[bus.cfg_idx] <= int'(bus.cfg_addr);
            m_exp[bus.cfg_idx]  <= int'(bus.cfg_data);
            m_en[bus.cfg_idx]   <= bus.cfg_en;
          end
          if (start) begin
            m_mode <= 1; m_cnt <= 0; m_run <= 0; m_fresh <= 1'b0;
            for (int i = 0; i < NCHAN; i++) m_cap[i] <= -1;
          end
        end
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge ph1) begin
    check("busy",    int'(busy),    int'(m_mode == 1 || m_mode == 2));
    check("done",    int'(done),    int'(m_mode >= 3));
    check("pass",    int'(pass),    int'(m_mode == 3));
    check("fail",    int'(fail),    int'(m_mode == 4 || m_mode == 5));
    check("timeout", int'(timeout), int'(m_mode == 5));
    if (m_mode == 4 || m_fresh) begin
      check("fail_idx",  int'(fail_idx),  m_fresh ? 0 : m_res);
      check("fail_data", int'(fail_data), m_fresh ? 0 : m_res_data);
    end
`ifdef TRM_CYCLE_REPORT_EN
    check("run_cycles", int'(run_cycles), m_run);
`endif
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge ph1);
    #2;
  endtask

  task automatic cfg(input int idx, input int addr, input int data, input bit en);
    bus.cfg_wr   = 1'b1;
    bus.cfg_idx  = IDX_W'(idx);
    bus.cfg_addr = ADDR_W'(addr);
    bus.cfg_data = 8'(data);
    bus.cfg_en   = en;
    step();
    bus.cfg_wr = 1'b0;
  endtask

  task automatic mem_write(input int addr, input int data);
    bus.mem_we    = 1'b1;
    bus.mem_addr  = ADDR_W'(addr);
    bus.mem_wdata = 8'(data);
    step();
    bus.mem_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_halt();
    halt = 1'b1;
    step();
    halt = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    for (int i = 0; i < limit && !done; i++) step();
    if (!done) check({name, "_wait_done"}, 0, 1);
  endtask

  initial begin
    bus.cfg_wr = 1'b0; bus.cfg_idx = '0; bus.cfg_addr = '0;
    bus.cfg_data = '0; bus.cfg_en = 1'b0;
    bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;

    repeat (3) step();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    resetb = 1'b1;
    step();

    // 1: single channel, correct byte, verdict after NCHAN+1 cycles
    cfg(0, 'h0015, 'h7F, 1'b1);
    do_start();
    mem_write('h0015, 'h7F);
    step();
    do_halt();
    repeat (NCHAN - 1) step();
    check("t1_done_early", int'(done), 0);
    step();
    check("t1_done", int'(done), 1);
    check("t1_pass", int'(pass), 1);

    // 2: last write wins; cfg writes during RUN are ignored
    do_start();
    mem_write('h0015, 'h7F);
    cfg(0, 'h0015, 'h80, 1'b1);
    mem_write('h0015, 'h80);
    do_halt();
    wait_done("t2", 20);
    check("t2_fail", int'(fail), 1);
    check("t2_fail_idx", int'(fail_idx), 0);
    check("t2_fail_data", int'(fail_data), 'h80);

    // 3: enabled channel never written
    cfg(1, 'h0020, 'h01, 1'b1);
    do_start();
    mem_write('h0015, 'h7F);
    do_halt();
    wait_done("t3", 20);
    check("t3_fail", int'(fail), 1);
    check("t3_fail_idx", int'(fail_idx), 1);
    check("t3_fail_data", int'(fail_data), 0);

    // shared address on two channels, cfg in the start cycle, write in exit cycle
    cfg(1, 'h0020, 'h01, 1'b0);
    cfg(2, 'h0030, 'h55, 1'b1);
    bus.cfg_wr = 1'b1; bus.cfg_idx = 2'd3; bus.cfg_addr = 16'h0030;
    bus.cfg_data = 8'h55; bus.cfg_en = 1'b1;
    do_start();
    bus.cfg_wr = 1'b0;
    mem_write('h0015, 'h7F);
    mem_write('h0030, 'h11);
    bus.mem_we = 1'b1; bus.mem_addr = 16'h0030; bus.mem_wdata = 8'h55;
    do_halt();
    bus.mem_we = 1'b0;
    wait_done("t_shared", 20);
    check("t_shared_pass", int'(pass), 1);

    // 4: timeout after exactly TIMEOUT_CYCLES RUN cycles
    do_start();
    repeat (TIMEOUT_CYCLES - 1) step();
    check("t4_not_yet", int'(timeout), 0);
    step();
    check("t4_timeout", int'(timeout), 1);
    check("t4_fail", int'(fail), 1);

    // 4b: halt in the final RUN cycle takes precedence over timeout
    do_start();
    repeat (TIMEOUT_CYCLES - 1) step();
    do_halt();
    check("t4b_busy", int'(busy), 1);
    check("t4b_timeout", int'(timeout), 0);
    wait_done("t4b", 20);
    check("t4b_fail_idx", int'(fail_idx), 0);
    check("t4b_timeout_end", int'(timeout), 0);

    // 5: reset mid-RUN clears outputs at once; reload and pass
    do_start();
    mem_write('h0015, 'h7F);
    step();
    #3 resetb = 1'b0;
    #1;
    check("t5_busy", int'(busy), 0);
    check("t5_done", int'(done), 0);
    check("t5_fail", int'(fail), 0);
    step();
    resetb = 1'b1;
    step();
    cfg(0, 'h0015, 'h7F, 1'b1);
    do_start();
    mem_write('h0015, 'h7F);
    do_halt();
    wait_done("t5", 20);
    check("t5_pass", int'(pass), 1);

`ifdef TRM_CYCLE_REPORT_EN
    // 6: halt 37 cycles after start
    do_start();
    repeat (36) step();
    do_halt();
    wait_done("t6", 20);
    check("t6_run_cycles", int'(run_cycles), 36);
    do_start();
    check("t6_cleared", int'(run_cycles), 0);
    do_halt();
    wait_done("t6b", 20);
`endif

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got 0 expected 1");
    $fatal(1);
  end
endmodule
